ripple_count_checker: RTL and testbench

Synthesizable checker for the 4-bit T flip-flop ripple counter in the T_FF example. It consumes the counter outputs q0..q3 and the counter's reset, and verifies that the counter advances by exactly one per clock with wrap 15→0. It flags discontinuities, counts errors and wraps, and reports lock status, so the example can self-check on hardware as well as in simulation.

---
 rtl/ripple_count_checker.sv | 135 +++++++++++++
 tb/tb_ripple_count_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ripple_count_checker.sv
// ripple_count_checker: watches a 4-bit ripple counter and verifies it advances by
// exactly one per clock, reporting lock, mismatch pulses, and saturating error/wrap counts.
`default_nettype none

module ripple_count_checker #(
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q0,
    input  logic             q1,
    input  logic             q2,
    input  logic             q3,
    input  logic             cnt_reset,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [3:0]       value
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] exp_val;
    logic [3:0] exp_nxt;
    logic [3:0] run;
    logic [3:0] run_nxt;
    logic [3:0] v;
    logic [3:0] v_inc;
    logic [3:0] run_inc;
    logic       match;
    logic       err_nxt;
    logic       wrap_hit;

    // The counter toggles on falling edges, so v is settled by the rising edge.
    assign v       = {q3, q2, q1, q0};
    assign v_inc   = v + 4'd1;
    assign run_inc = run + 4'd1;
    assign match   = (v == exp_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cnt_reset) begin
            state_nxt = S_HOLD;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_ACQUIRE;
                S_ACQUIRE: if (match && (run_inc == LOCK_RUN)) state_nxt = S_LOCKED;
                S_LOCKED:  if (!match) state_nxt = S_ACQUIRE;
                S_HOLD:    state_nxt = S_ACQUIRE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath decode; the counter's own reset overrides every state's tracking.
    always_comb begin
        err_nxt  = 1'b0;
        wrap_hit = 1'b0;
        exp_nxt  = v_inc;
        run_nxt  = 4'd0;
        if (cnt_reset) begin
            err_nxt = (v != 4'd0);
            exp_nxt = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    exp_nxt = v_inc;
                end
                S_ACQUIRE: begin
                    if (match) run_nxt = run_inc;
                end
                S_LOCKED: begin
                    if (match) begin
                        run_nxt  = run;
                        wrap_hit = (v == 4'd0);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    err_nxt = (v != 4'd0);
                    exp_nxt = 4'd1;
                end
                default: begin
                    exp_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_val    <= 4'd0;
            run        <= 4'd0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            value      <= 4'd0;
        end else begin
            exp_val <= exp_nxt;
            run     <= run_nxt;
            locked  <= (state_nxt == S_LOCKED);
            err     <= err_nxt;
            value   <= v;
            if (err_nxt && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (wrap_hit && (wrap_count != CNT_MAX)) begin
                wrap_count <= wrap_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ripple_count_checker.sv
// tb_ripple_count_checker: table-driven scoreboard bench for ripple_count_checker,
// with a second instance at CNT_W=2 sharing the stimulus to observe saturation.
`default_nettype none

module tb_ripple_count_checker;

    typedef struct {
        logic       cr;
        logic [3:0] v;
        logic       lk;
        logic       er;
        int         ec;
        int         wc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       q0, q1, q2, q3;
    logic       cnt_reset;
    logic       locked, err;
    logic [7:0] err_count, wrap_count;
    logic [3:0] value;
    logic       locked2, err2;
    logic [1:0] err_count2, wrap_count2;
    logic [3:0] value2;

    int checks = 0;
    int errors = 0;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    ripple_count_checker #(.LOCK_LEN(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .cnt_reset(cnt_reset), .locked(locked), .err(err),
        .err_count(err_count), .wrap_count(wrap_count), .value(value)
    );

    ripple_count_checker #(.LOCK_LEN(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .cnt_reset(cnt_reset), .locked(locked2), .err(err2),
        .err_count(err_count2), .wrap_count(wrap_count2), .value(value2)
    );

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string name, input int step, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, expv);
        end
    endtask

    task automatic add(input vec_t t);
        tbl_b.push_back(t);
    endtask

    task automatic check_cleared(input int step);
        chk("rst_locked", step, int'(locked), 0);
        chk("rst_err", step, int'(err), 0);
        chk("rst_err_count", step, int'(err_count), 0);
        chk("rst_wrap_count", step, int'(wrap_count), 0);
        chk("rst_value", step, int'(value), 0);
        chk("rst_locked2", step, int'(locked2), 0);
        chk("rst_err_count2", step, int'(err_count2), 0);
    endtask

    // Drive on the falling edge like the real counter; compare just after the rising edge.
    task automatic apply(input vec_t t, input int step);
        vec_t e;
        @(negedge clk);
        {q3, q2, q1, q0} = t.v;
        cnt_reset = t.cr;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked", step, int'(locked), int'(e.lk));
        chk("err", step, int'(err), int'(e.er));
        chk("err_count", step, int'(err_count), e.ec);
        chk("wrap_count", step, int'(wrap_count), e.wc);
        chk("value", step, int'(value), int'(e.v));
        chk("locked2", step, int'(locked2), int'(e.lk));
        chk("err2", step, int'(err2), int'(e.er));
        chk("err_count2", step, int'(err_count2), sat3(e.ec));
        chk("wrap_count2", step, int'(wrap_count2), sat3(e.wc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean count from zero: lock on the 4th sample, wraps at samples 16 and 32.
        for (int i = 0; i < 40; i++) begin
            tbl_a.push_back('{1'b0, 4'(i % 16), (i >= 3), 1'b0, 0,
                              int'(i >= 16) + int'(i >= 32)});
        end
        // Glitch 9 in place of 7 while locked, relock at 12.
        add('{1'b0, 4'd0,  1'b0, 1'b0, 0, 0});
        add('{1'b0, 4'd1,  1'b0, 1'b0, 0, 0});
        add('{1'b0, 4'd2,  1'b0, 1'b0, 0, 0});
        add('{1'b0, 4'd3,  1'b1, 1'b0, 0, 0});
        add('{1'b0, 4'd4,  1'b1, 1'b0, 0, 0});
        add('{1'b0, 4'd5,  1'b1, 1'b0, 0, 0});
        add('{1'b0, 4'd6,  1'b1, 1'b0, 0, 0});
        add('{1'b0, 4'd9,  1'b0, 1'b1, 1, 0});
        add('{1'b0, 4'd10, 1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd11, 1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd12, 1'b1, 1'b0, 1, 0});
        add('{1'b0, 4'd13, 1'b1, 1'b0, 1, 0});
        // Counter reset with v=0: no err, relock three steps after release.
        for (int i = 0; i < 3; i++) add('{1'b1, 4'd0, 1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd0,  1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd1,  1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd2,  1'b0, 1'b0, 1, 0});
        add('{1'b0, 4'd3,  1'b1, 1'b0, 1, 0});
        add('{1'b0, 4'd4,  1'b1, 1'b0, 1, 0});
        // Counter reset with v stuck at 5: four back-to-back pulses.
        for (int i = 0; i < 4; i++) add('{1'b1, 4'd5, 1'b0, 1'b1, 2 + i, 0});
        add('{1'b0, 4'd0,  1'b0, 1'b0, 5, 0});
        // Stuck at 7: never locks, never errs.
        for (int i = 0; i < 6; i++) add('{1'b0, 4'd7, 1'b0, 1'b0, 5, 0});
        // Resume, lock at 10, then a locked mismatch while the narrow counter is saturated.
        add('{1'b0, 4'd8,  1'b0, 1'b0, 5, 0});
        add('{1'b0, 4'd9,  1'b0, 1'b0, 5, 0});
        add('{1'b0, 4'd10, 1'b1, 1'b0, 5, 0});
        add('{1'b0, 4'd15, 1'b0, 1'b1, 6, 0});
        add('{1'b0, 4'd0,  1'b0, 1'b0, 6, 0});
        add('{1'b0, 4'd1,  1'b0, 1'b0, 6, 0});
        add('{1'b0, 4'd2,  1'b1, 1'b0, 6, 0});
        add('{1'b0, 4'd3,  1'b1, 1'b0, 6, 0});

        reset     = 1'b0;
        cnt_reset = 1'b0;
        {q3, q2, q1, q0} = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared(-1);
        reset = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], i);

        // Asynchronous reset between edges must clear outputs without a clock.
        reset = 1'b0;
        #1;
        check_cleared(-2);
        reset = 1'b1;

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], 100 + i);

        chk("scoreboard_empty", -3, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
